// File: rtl/bit_serial_exec_pkg.sv
// Shared definitions for the bit-serial CPU: opcodes, execute-stage states
// and opcode classification helpers.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDI = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Opcodes that run through the serial ALU for WIDTH cycles.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OP_LDI) && (op <= OP_NOT);
   endfunction

   // Upper half of the opcode space is reserved.
   function automatic logic is_reserved(input logic [3:0] op);
      return op[3];
   endfunction

endpackage

// File: rtl/bit_serial_exec_if.sv
// Instruction handshake between the two-nibble loader (master) and the
// execute stage (slave).
interface bit_serial_exec_if #(
   parameter int WIDTH = 12
);
   logic             instr_valid;
   logic             instr_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] operand;

   modport master (output instr_valid, opcode, operand, input instr_ready);
   modport slave  (input instr_valid, opcode, operand, output instr_ready);
endinterface

// File: rtl/bit_serial_exec_alu_bit.sv
// Combinational 1-bit ALU slice; the carry flop lives in the caller.
module serial_alu_bit
   import cpu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       carry_in,
   input  logic [3:0] opcode,
   output logic       res,
   output logic       carry_out
);

   logic b_inv;
   assign b_inv = ~b;

   // Bitwise function select; subtract is add of the inverted operand.
   always_comb begin
      res       = 1'b0;
      carry_out = 1'b0;
      case (opcode)
         OP_LDI: res = b;
         OP_ADD: begin
            res       = a ^ b ^ carry_in;
            carry_out = (a & b) | (a & carry_in) | (b & carry_in);
         end
         OP_SUB: begin
            res       = a ^ b_inv ^ carry_in;
            carry_out = (a & b_inv) | (a & carry_in) | (b_inv & carry_in);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_NOT: res = ~a;
         default: res = 1'b0;
      endcase
   end

endmodule

// File: rtl/bit_serial_exec.sv
// Execute stage of the bit-serial CPU: one instruction at a time, LSB-first
// through a 1-bit ALU against the accumulator, one bit per clock.
//
// state | meaning
// IDLE  | ready for an instruction; latch opcode/operand on accept
// EXEC  | one result bit per cycle, WIDTH cycles; flags commit on the last
// DONE  | one-cycle retire strobe (plus illegal for reserved opcodes)
module bit_serial_exec
   import cpu_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   bit_serial_exec_if.slave instr,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic             serial_bit,
   output logic [WIDTH-1:0] acc_out,
   output logic             flag_z,
   output logic             flag_c
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           state;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] b_sr;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             run_zero;
   logic             res;
   logic             cout;
   logic             last_bit;
   logic             arith;

   serial_alu_bit u_alu (
      .a         (acc[0]),
      .b         (b_sr[0]),
      .carry_in  (carry),
      .opcode    (op_q),
      .res       (res),
      .carry_out (cout)
   );

   assign last_bit          = (cnt == CNT_W'(WIDTH - 1));
   assign arith             = (op_q == OP_ADD) || (op_q == OP_SUB);
   assign instr.instr_ready = (state == IDLE);
   assign busy              = (state != IDLE);
   assign done              = (state == DONE);
   assign illegal           = done && is_reserved(op_q);
   assign serial_bit        = (state == EXEC) && res;
   assign acc_out           = acc;

   // Sequencer and serial datapath; reset mid-EXEC discards the partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op_q     <= OP_NOP;
         acc      <= '0;
         b_sr     <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         run_zero <= 1'b0;
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (instr.instr_valid) begin
                  op_q     <= instr.opcode;
                  b_sr     <= instr.operand;
                  cnt      <= '0;
                  carry    <= (instr.opcode == OP_SUB);
                  run_zero <= 1'b1;
                  state    <= is_alu_op(instr.opcode) ? EXEC : DONE;
               end
            end
            EXEC: begin
               acc  <= {res, acc[WIDTH-1:1]};
               b_sr <= b_sr >> 1;
               cnt  <= cnt + 1'b1;
               if (arith) carry <= cout;
               if (res) run_zero <= 1'b0;
               if (last_bit) begin
                  state  <= DONE;
                  flag_z <= run_zero && !res;
                  flag_c <= arith && cout;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_exec.sv
// Self-checking bench for bit_serial_exec (WIDTH=12): directed vector table,
// reset-abort sequence and randomized instructions against an arithmetic model.
module tb_bit_serial_exec;
   import cpu_pkg::*;

   localparam int W = 12;

   logic         clk;
   logic         rst_n;
   logic         busy, done, illegal, serial_bit, flag_z, flag_c;
   logic [W-1:0] acc_out;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] m_acc;
   logic         m_z, m_c;

   bit_serial_exec_if #(.WIDTH(W)) bus ();

   bit_serial_exec #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr      (bus),
      .busy       (busy),
      .done       (done),
      .illegal    (illegal),
      .serial_bit (serial_bit),
      .acc_out    (acc_out),
      .flag_z     (flag_z),
      .flag_c     (flag_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] opnd;
      logic [W-1:0] acc;
      logic         z;
      logic         c;
      logic         ill;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Architectural effect of one instruction, from plain arithmetic.
   task automatic model(input logic [3:0] op, input logic [W-1:0] b);
      logic [W:0] sum;
      if (op >= 4'd1 && op <= 4'd7) begin
         m_c = 1'b0;
         case (op)
            4'd1: m_acc = b;
            4'd2: begin
               sum   = {1'b0, m_acc} + {1'b0, b};
               m_c   = sum[W];
               m_acc = sum[W-1:0];
            end
            4'd3: begin
               m_c   = (m_acc >= b);
               m_acc = m_acc - b;
            end
            4'd4: m_acc = m_acc & b;
            4'd5: m_acc = m_acc | b;
            4'd6: m_acc = m_acc ^ b;
            default: m_acc = ~m_acc;
         endcase
         m_z = (m_acc == '0);
      end
   endtask

   // Issue one instruction, hold valid through busy with scrambled fields,
   // and check latency, ready, strobes and the serial bit stream.
   task automatic run_instr(input logic [3:0] op, input logic [W-1:0] opnd,
                            input bit exp_alu, input bit exp_ill);
      int           cyc;
      int           wait_n;
      bit           seen;
      logic [W-1:0] stream;
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.opcode      = op;
      bus.operand     = opnd;
      wait_n = 0;
      while (!bus.instr_ready && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      if (!bus.instr_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         bus.instr_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.opcode  = 4'($urandom);
      bus.operand = W'($urandom);
      cyc    = 1;
      seen   = 0;
      stream = '0;
      while (cyc <= W + 5 && !seen) begin
         if (done) begin
            seen = 1;
         end else begin
            chk("ready_low_busy", 32'(bus.instr_ready), 32'd0);
            if (exp_alu && cyc <= W) stream[cyc-1] = serial_bit;
            @(posedge clk); #1;
            cyc++;
         end
      end
      bus.instr_valid = 1'b0;
      if (!seen) begin
         chk("done_timeout", 32'd0, 32'd1);
         return;
      end
      chk("done_cycle", 32'(cyc), exp_alu ? 32'(W + 1) : 32'd1);
      chk("illegal", 32'(illegal), 32'(exp_ill));
      chk("busy_in_done", 32'(busy), 32'd1);
      chk("serial_in_done", 32'(serial_bit), 32'd0);
      @(posedge clk); #1;
      chk("ready_after", 32'(bus.instr_ready), 32'd1);
      chk("done_one_cycle", 32'(done), 32'd0);
      if (exp_alu) chk("serial_stream", 32'(stream), 32'(acc_out));
   endtask

   initial begin
      vecs[0]  = '{4'h1, 12'h0A5, 12'h0A5, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'h1, 12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{4'h2, 12'h001, 12'h000, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{4'h1, 12'h005, 12'h005, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{4'h3, 12'h007, 12'hFFE, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{4'h1, 12'h005, 12'h005, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{4'h3, 12'h005, 12'h000, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{4'h1, 12'hF0F, 12'hF0F, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{4'h6, 12'h0FF, 12'hFF0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{4'h4, 12'h0F0, 12'h0F0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{4'h7, 12'hABC, 12'hF0F, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{4'h1, 12'h123, 12'h123, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{4'h2, 12'hEDD, 12'h000, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{4'hB, 12'h777, 12'h000, 1'b1, 1'b1, 1'b1};
      vecs[14] = '{4'h1, 12'h123, 12'h123, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{4'hF, 12'h000, 12'h123, 1'b0, 1'b0, 1'b1};
      vecs[16] = '{4'h0, 12'h456, 12'h123, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{4'h5, 12'h800, 12'h923, 1'b0, 1'b0, 1'b0};

      rst_n           = 1'b0;
      bus.instr_valid = 1'b0;
      bus.opcode      = 4'h0;
      bus.operand     = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(bus.instr_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_serial", 32'(serial_bit), 32'd0);
      chk("rst_acc", 32'(acc_out), 32'd0);
      chk("rst_z", 32'(flag_z), 32'd0);
      chk("rst_c", 32'(flag_c), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         run_instr(vecs[i].op, vecs[i].opnd, is_alu_op(vecs[i].op), vecs[i].ill);
         chk($sformatf("vec%0d_acc", i), 32'(acc_out), 32'(vecs[i].acc));
         chk($sformatf("vec%0d_z", i), 32'(flag_z), 32'(vecs[i].z));
         chk($sformatf("vec%0d_c", i), 32'(flag_c), 32'(vecs[i].c));
      end

      // Idle with valid low: no spurious retire after held-valid instructions.
      repeat (3) begin
         @(negedge clk);
         chk("no_dup_done", 32'(done), 32'd0);
      end

      // Reset in the sixth EXEC cycle of an ADD aborts without a done.
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.opcode      = OP_ADD;
      bus.operand     = 12'h001;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_acc", 32'(acc_out), 32'd0);
      chk("abort_z", 32'(flag_z), 32'd0);
      chk("abort_c", 32'(flag_c), 32'd0);
      chk("abort_ready", 32'(bus.instr_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'd0);
         chk("abort_ready_held", 32'(bus.instr_ready), 32'd1);
      end
      rst_n = 1'b1;
      m_acc = '0;
      m_z   = 1'b0;
      m_c   = 1'b0;

      // Randomized instruction stream against the arithmetic model.
      for (int i = 0; i < 60; i++) begin
         logic [3:0]   op;
         logic [W-1:0] opnd;
         op   = 4'($urandom_range(0, 15));
         opnd = W'($urandom);
         if (i % 7 == 0) op = OP_LDI;
         model(op, opnd);
         run_instr(op, opnd, is_alu_op(op), is_reserved(op));
         chk("rand_acc", 32'(acc_out), 32'(m_acc));
         chk("rand_z", 32'(flag_z), 32'(m_z));
         chk("rand_c", 32'(flag_c), 32'(m_c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bit_serial_exec.md
Name: bit_serial_exec

Overview:
- Execute stage of the bit-serial CPU; sits directly downstream of the two-nibble instruction loader.
- Accepts one {opcode, operand} instruction through a valid/ready handshake.
- Executes the instruction LSB-first through a 1-bit ALU against a WIDTH-bit accumulator, one bit per clock.
- Exposes the accumulator, Z/C flags and completion strobes for the LED / 7-segment display logic.

Parameters:
- WIDTH, 12, accumulator and operand width in bits; legal range 4..16.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  loader has a complete instruction.
- instr_ready  output  1  block can accept an instruction; high only in IDLE.
- opcode  input  4  instruction opcode.
- operand  input  WIDTH  immediate operand.
- busy  output  1  high in EXEC and DONE.
- done  output  1  one-cycle strobe when the instruction retires.
- illegal  output  1  one-cycle strobe, coincident with done, for reserved opcodes.
- serial_bit  output  1  ALU result bit of the current EXEC cycle; 0 otherwise.
- acc_out  output  WIDTH  accumulator; architecturally valid only while busy=0.
- flag_z  output  1  zero flag.
- flag_c  output  1  carry / no-borrow flag.

Behaviour:
- Reset and clock: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: state=IDLE, acc=0, operand shift register=0, carry=0, counter=0, flag_z=0, flag_c=0, done=0, illegal=0, busy=0, instr_ready=1, serial_bit=0.
- Opcodes: 0 NOP, 1 LDI (acc=op), 2 ADD (acc+op), 3 SUB (acc-op), 4 AND, 5 OR, 6 XOR, 7 NOT (acc=~acc; operand ignored). 8-15 reserved.
- IDLE:
  - On instr_valid & instr_ready, latch opcode and load operand into the B shift register.
  - Clear the counter. Preset carry to 1 for SUB, 0 otherwise. Preset running-zero to 1.
  - ALU opcodes (1-7) go to EXEC. NOP and reserved opcodes go straight to DONE.
- EXEC, once per cycle for exactly WIDTH cycles:
  - Compute res=f(acc[0], b[0], carry).
  - Update acc <= {res, acc[WIDTH-1:1]} and b <= b>>1.
  - For ADD/SUB, carry <= carry-out; SUB uses ~b[0].
  - If res=1, clear running-zero.
  - serial_bit=res.
  - On the cycle where counter==WIDTH-1, go to DONE and commit flags on the same edge:
    - flag_z=running-zero after the final bit.
    - flag_c=final carry-out for ADD/SUB; flag_c=0 for LDI/AND/OR/XOR/NOT.
- DONE: done=1 for one cycle; illegal=1 if the opcode is reserved. Next state is always IDLE.
- Latency, with the accept cycle as cycle 0:
  - ALU ops: done in cycle WIDTH+1.
  - NOP/reserved: done in cycle 1.
  - Earliest next accept: cycle WIDTH+2 for ALU ops, cycle 2 for NOP/reserved.
- NOP and reserved opcodes leave acc and both flags unchanged.
- instr_valid while busy is ignored. The loader must hold it; no instruction is dropped or duplicated.
- opcode and operand are sampled only in the accept cycle; later changes have no effect.
- Arithmetic wraps modulo 2^WIDTH. SUB sets C=1 for no borrow (acc>=op unsigned).
- Reset asserted mid-EXEC aborts immediately to reset values. No done is issued and the partial result is discarded.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_NOT);
  - state_t enum {IDLE, EXEC, DONE};
  - an is_alu_op function.
  The loader/top also imports cpu_pkg.
- One sub-module, serial_alu_bit: combinational 1-bit ALU that takes a, b, carry_in and opcode and returns res and carry_out. The carry flop stays in bit_serial_exec.

Test Plan:
- Reset, then LDI 0x0A5 -> instr_ready low for cycles 1-13; done in cycle 13; acc_out=0x0A5, flag_z=0, flag_c=0.
- LDI 0xFFF, then ADD 0x001 -> acc_out=0x000, flag_z=1, flag_c=1; serial_bit=0 on all 12 EXEC cycles.
- LDI 0x005, SUB 0x007 -> acc_out=0xFFE, flag_c=0, flag_z=0. Then LDI 0x005, SUB 0x005 -> acc_out=0x000, flag_c=1, flag_z=1.
- LDI 0xF0F, XOR 0x0FF -> acc_out=0xFF0. Then AND 0x0F0 -> 0x0F0. Then NOT -> 0xF0F, flag_c=0.
- With acc=0x123, Z=1, C=1, issue opcode 0xB -> done and illegal both high in cycle 1; acc and flags unchanged. instr_valid held high through busy -> exactly one accept per instruction.
- Start ADD 0x001, assert rst_n low in EXEC cycle 6 -> acc_out=0, flags=0, instr_ready=1 while reset is held; no done pulse.
